// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO read side: default widths and burst FSM state encoding.
package fifo_rd_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int LEN_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO read port, burst control and output stream of the burst reader, bundled as one interface.
interface fifo_burst_reader_if
   import fifo_rd_pkg::*;
#(
   parameter int Width = WIDTH_DEF,
   parameter int LenW  = LEN_W_DEF
);

   logic             EF;
   logic [Width-1:0] FifoData;
   logic             R;
   logic             Start;
   logic [LenW-1:0]  Len;
   logic             Abort;
   logic [Width-1:0] DataOut;
   logic             Valid;
   logic             Ready;
   logic             Busy;
   logic             Done;
   logic [LenW-1:0]  Sent;

   modport master (
      input  EF, FifoData, Start, Len, Abort, Ready,
      output R, DataOut, Valid, Busy, Done, Sent
   );

   modport slave (
      output EF, FifoData, Start, Len, Abort, Ready,
      input  R, DataOut, Valid, Busy, Done, Sent
   );

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry register buffer; entry e0 is always the head. Flush wins over push/pop.
module fifo_rd_skid #(
   parameter int Width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [Width-1:0] din,
   output logic [Width-1:0] head,
   output logic [1:0]       cnt
);

   logic [Width-1:0] e0, e1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e0  <= '0;
         e1  <= '0;
         cnt <= 2'd0;
      end else if (flush) begin
         cnt <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (cnt == 2'd0) e0 <= din;
               else             e1 <= din;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               e0  <= e1;
               cnt <= cnt - 2'd1;
            end
            2'b11: begin
               // Count unchanged; the new word goes behind whatever remains.
               if (cnt == 2'd2) begin
                  e0 <= e1;
                  e1 <= din;
               end else begin
                  e0 <= din;
               end
            end
            default: cnt <= cnt;
         endcase
      end
   end

   assign head = e0;

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains Len words per burst from the FIFO read port and re-presents them on a valid/ready stream.
module fifo_burst_reader
   import fifo_rd_pkg::*;
#(
   parameter int Width = WIDTH_DEF,
   parameter int LenW  = LEN_W_DEF
) (
   input logic                clk,
   input logic                rst,
   fifo_burst_reader_if.master bus
);

   state_t           state, state_nxt;
   logic [LenW-1:0]  rem_issue, rem_deliver, sent;
   logic             inflight, done, rd, flush, pop, valid, last_pop, room;
   logic [1:0]       buf_cnt;
   logic [Width-1:0] head;
   logic [2:0]       occ;

   fifo_rd_skid #(.Width(Width)) u_skid (
      .clk   (clk),
      .rst   (rst),
      .push  (inflight),
      .pop   (pop),
      .flush (flush),
      .din   (bus.FifoData),
      .head  (head),
      .cnt   (buf_cnt)
   );

   assign valid    = (buf_cnt != 2'd0) && (state == ST_RUN);
   assign pop      = valid && bus.Ready;
   assign last_pop = pop && (rem_deliver == LenW'(1));
   // A word leaving this cycle frees a slot, which keeps reads back-to-back.
   assign occ      = {1'b0, buf_cnt} + {2'b0, inflight};
   assign room     = occ < (3'd2 + {2'b0, pop});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      rd        = 1'b0;
      flush     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.Start && bus.Len != '0) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (last_pop)       state_nxt = ST_IDLE;
            else if (bus.Abort) state_nxt = ST_FLUSH;
            else                rd = !bus.EF && (rem_issue != '0) && room;
         end
         ST_FLUSH: begin
            if (!inflight) begin
               flush     = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_issue   <= '0;
         rem_deliver <= '0;
         sent        <= '0;
         inflight    <= 1'b0;
         done        <= 1'b0;
      end else begin
         done     <= 1'b0;
         inflight <= rd;
         if (state == ST_IDLE && bus.Start) begin
            sent <= '0;
            if (bus.Len == '0) begin
               done <= 1'b1;
            end else begin
               rem_issue   <= bus.Len;
               rem_deliver <= bus.Len;
            end
         end
         if (rd) rem_issue <= rem_issue - LenW'(1);
         if (pop) begin
            sent        <= sent + LenW'(1);
            rem_deliver <= rem_deliver - LenW'(1);
            if (rem_deliver == LenW'(1)) done <= 1'b1;
         end
      end
   end

   assign bus.R       = rd;
   assign bus.Valid   = valid;
   assign bus.DataOut = head;
   assign bus.Busy    = (state != ST_IDLE);
   assign bus.Done    = done;
   assign bus.Sent    = sent;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural FIFO (R at posedge -> data next cycle).
module tb_fifo_burst_reader;
   import fifo_rd_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fifo_burst_reader_if #(.Width(8), .LenW(8)) bus ();
   fifo_burst_reader #(.Width(8), .LenW(8)) dut (.clk(clk), .rst(rst), .bus(bus));

   // FIFO model: the initial block writes, the posedge process reads.
   logic [7:0] mem [0:255];
   int wr_idx = 0;
   int rd_idx = 0;
   assign bus.EF = (wr_idx == rd_idx);

   always @(posedge clk) begin
      if (bus.R) begin
         bus.FifoData <= mem[rd_idx % 256];
         rd_idx       <= rd_idx + 1;
      end
   end

   // Stream monitor
   int r_cnt = 0, done_cnt = 0, cyc = 0;
   int r_cyc[$];
   int out_cyc[$];
   logic [7:0] out_q[$];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.R) begin
         r_cnt <= r_cnt + 1;
         r_cyc.push_back(cyc);
      end
      if (bus.Valid && bus.Ready) begin
         out_q.push_back(bus.DataOut);
         out_cyc.push_back(cyc);
      end
      if (bus.Done) done_cnt <= done_cnt + 1;
   end

   int checks = 0, errors = 0;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_word(input logic [7:0] d);
      mem[wr_idx % 256] = d;
      wr_idx++;
   endtask

   task automatic start(input int len);
      bus.Start = 1'b1;
      bus.Len   = len[7:0];
      @(negedge clk);
      bus.Start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input string tag);
      int n = 0;
      while (done_cnt == d0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(tag, int'(done_cnt != d0), 1);
   endtask

   task automatic chk_words(input string tag, input int o0, input int m0, input int n);
      chk({tag, "_cnt"}, out_q.size() - o0, n);
      for (int k = 0; k < n && (o0 + k) < out_q.size(); k++)
         chk({tag, "_word"}, int'(out_q[o0+k]), int'(mem[(m0+k) % 256]));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_R"},       int'(bus.R), 0);
      chk({tag, "_Valid"},   int'(bus.Valid), 0);
      chk({tag, "_DataOut"}, int'(bus.DataOut), 0);
      chk({tag, "_Busy"},    int'(bus.Busy), 0);
      chk({tag, "_Done"},    int'(bus.Done), 0);
      chk({tag, "_Sent"},    int'(bus.Sent), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int r0, o0, d0, m0, rc0, rs, n;
      logic [7:0] hold_d;
      bit stable;

      bus.Start = 1'b0;
      bus.Len   = '0;
      bus.Abort = 1'b0;
      bus.Ready = 1'b0;
      tick(2);
      chk_all_zero("reset");
      rst = 1'b0;
      tick(1);

      // 1: three preloaded words, consumer always ready
      push_word(8'd5); push_word(8'd9); push_word(8'd13);
      bus.Ready = 1'b1;
      r0 = r_cnt; o0 = out_q.size(); d0 = done_cnt; m0 = rd_idx; rc0 = r_cyc.size();
      start(3);
      wait_done(d0, "t1_done");
      chk("t1_r_cnt", r_cnt - r0, 3);
      chk("t1_r_consec", (r_cyc.size() >= rc0 + 3) ? r_cyc[rc0+2] - r_cyc[rc0] : -1, 2);
      chk_words("t1", o0, m0, 3);
      chk("t1_out_consec", (out_cyc.size() >= o0 + 3) ? out_cyc[o0+2] - out_cyc[o0] : -1, 2);
      chk("t1_latency", (out_cyc.size() > o0 && r_cyc.size() > rc0) ? out_cyc[o0] - r_cyc[rc0] : -1, 2);
      chk("t1_sent", int'(bus.Sent), 3);
      tick(2);
      chk("t1_done_once", done_cnt - d0, 1);
      chk("t1_busy", int'(bus.Busy), 0);

      // 2: eight words with a six-cycle consumer stall mid-burst
      for (int i = 0; i < 8; i++) push_word(8'(32 + i));
      o0 = out_q.size(); d0 = done_cnt; m0 = rd_idx;
      start(8);
      n = 0;
      while (out_q.size() - o0 < 2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      bus.Ready = 1'b0;
      rs = r_cnt; hold_d = bus.DataOut; stable = bus.Valid;
      repeat (6) begin
         @(negedge clk);
         if (bus.DataOut !== hold_d || bus.Valid !== 1'b1) stable = 1'b0;
      end
      chk("t2_stable", int'(stable), 1);
      chk("t2_stall_r_le2", int'((r_cnt - rs) <= 2), 1);
      bus.Ready = 1'b1;
      wait_done(d0, "t2_done");
      chk_words("t2", o0, m0, 8);
      chk("t2_sent", int'(bus.Sent), 8);

      // 3: empty FIFO at start, words trickle in later
      r0 = r_cnt; o0 = out_q.size(); d0 = done_cnt; m0 = rd_idx;
      start(4);
      tick(5);
      chk("t3_busy", int'(bus.Busy), 1);
      chk("t3_no_r", r_cnt - r0, 0);
      chk("t3_no_valid", int'(bus.Valid), 0);
      for (int i = 0; i < 4; i++) begin
         push_word(8'(160 + i));
         tick(1);
      end
      wait_done(d0, "t3_done");
      chk_words("t3", o0, m0, 4);
      chk("t3_sent", int'(bus.Sent), 4);

      // 4: abort after two words delivered
      for (int i = 0; i < 6; i++) push_word(8'(96 + i));
      o0 = out_q.size(); d0 = done_cnt; m0 = rd_idx;
      start(6);
      n = 0;
      while (bus.Sent != 8'd2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      bus.Ready = 1'b0;
      bus.Abort = 1'b1;
      #1;
      chk("t4_r_abort", int'(bus.R), 0);
      @(negedge clk);
      bus.Abort = 1'b0;
      tick(4);
      chk("t4_valid", int'(bus.Valid), 0);
      chk("t4_busy", int'(bus.Busy), 0);
      chk("t4_sent", int'(bus.Sent), 2);
      chk("t4_no_done", done_cnt - d0, 0);
      chk_words("t4", o0, m0, 2);
      bus.Ready = 1'b1;

      // 5: zero-length burst, then Start while busy
      r0 = r_cnt; d0 = done_cnt;
      start(0);
      chk("t5_done_pulse", int'(bus.Done), 1);
      chk("t5_sent0", int'(bus.Sent), 0);
      tick(3);
      chk("t5_done_once", done_cnt - d0, 1);
      chk("t5_no_r", r_cnt - r0, 0);
      chk("t5_idle", int'(bus.Busy), 0);
      for (int i = 0; i < 3; i++) push_word(8'(200 + i));
      bus.Ready = 1'b0;
      o0 = out_q.size(); d0 = done_cnt; m0 = rd_idx;
      start(3);
      tick(2);
      chk("t5_busy", int'(bus.Busy), 1);
      start(7);
      tick(1);
      bus.Ready = 1'b1;
      wait_done(d0, "t5_done");
      chk_words("t5", o0, m0, 3);
      chk("t5_sent", int'(bus.Sent), 3);

      // 6: async reset mid-burst, then a fresh burst
      for (int i = 0; i < 4; i++) push_word(8'(80 + i));
      start(4);
      tick(2);
      #2 rst = 1'b1;
      #1;
      chk_all_zero("t6_rst");
      @(negedge clk);
      rst = 1'b0;
      tick(1);
      push_word(8'd17); push_word(8'd34);
      o0 = out_q.size(); d0 = done_cnt; m0 = rd_idx;
      start(2);
      wait_done(d0, "t6_done");
      chk_words("t6", o0, m0, 2);
      chk("t6_sent", int'(bus.Sent), 2);

      tick(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
